lock_access_ctrl: RTL

LOCK_ACCESS_CTRL -- requirements
Module: lock_access_ctrl

---
 rtl/lock_ctrl_pkg.sv | 23 ++
 rtl/rr_arbiter_2.sv | 20 ++
 rtl/lock_access_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lock_ctrl_pkg.sv
// Shared definitions for the lock access controller: state encoding,
// parameter defaults and the saturating failure-count helper.
package lock_ctrl_pkg;

    localparam int unsigned DEF_MAX_FAILS      = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32;

    localparam logic [2:0] FAIL_CNT_MAX = 3'd7;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSession = 2'd1,
        StOpen    = 2'd2,
        StLockout = 2'd3
    } state_e;

    // Increment the consecutive-failure count, holding at 7.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == FAIL_CNT_MAX) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter. On contention the requester that was
// not granted most recently wins; a single requester always wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_gnt,  // index of the most recently granted requester
    output logic [1:0] winner
);

    // Pick a one-hot winner from the request vector.
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last_gnt ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/lock_access_ctrl.sv
// Access controller sharing one combination-lock FSM between two requesters.
// Grants a session round-robin, muxes keypad signals to the lock, reports
// pass/fail, holds the door open for the owner and enforces a lockout after
// MAX_FAILS consecutive failures.
// Optional build macro LOCK_TIMEOUT_EN adds a session timeout that counts as
// a lock error after TIMEOUT_CYCLES cycles in SESSION.
module lock_access_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] u_comb1,
    input  logic [1:0] u_comb2,
    input  logic [1:0] u_enter,
    output logic [1:0] gnt,
    output logic       lock_reset,
    output logic       lock_comb1,
    output logic       lock_comb2,
    output logic       lock_enter,
    input  logic       lock_error,
    input  logic       lock_unlock,
    output logic       pass,
    output logic       fail,
    output logic       unlocked,
    output logic       lockout,
    output logic [2:0] fail_cnt
);

    if (MAX_FAILS < 1 || MAX_FAILS > 7 || LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 2)
    begin : g_bad_params
        $error("lock_access_ctrl: parameter out of range");
    end

    localparam int unsigned    LoW       = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LoW-1:0] LoLast    = LoW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]     MaxFails  = 3'(MAX_FAILS);

    state_e         state_q, state_d;
    logic [1:0]     gnt_q, gnt_d;
    logic           rr_ptr_q, rr_ptr_d;  // requester holding priority on contention
    logic [2:0]     fail_cnt_q, fail_cnt_d;
    logic           pass_q, pass_d;
    logic           fail_q, fail_d;
    logic [LoW-1:0] lo_cnt_q, lo_cnt_d;

    logic [1:0]     arb_winner;
    logic           owner_req;
    logic           in_session;
    logic           timed_out;
    logic [2:0]     fail_cnt_inc;

    rr_arbiter_2 u_arb (
        .req      (req),
        .last_gnt (~rr_ptr_q),
        .winner   (arb_winner)
    );

    assign in_session   = (state_q == StSession);
    assign owner_req    = |(req & gnt_q);
    assign fail_cnt_inc = sat_inc3(fail_cnt_q);

`ifdef LOCK_TIMEOUT_EN
    localparam int unsigned    ToW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    assign timed_out = in_session && (to_cnt_q == ToLast);

    // Count cycles spent in SESSION; restart from zero on every new session.
    always_comb begin
        to_cnt_d = '0;
        if (in_session) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
    end

    // Session timeout counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // Next-state logic: error beats unlock, any result beats a dropped request.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        fail_cnt_d = fail_cnt_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        lo_cnt_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d  = StSession;
                    gnt_d    = arb_winner;
                    // Winner 0 hands priority to requester 1 and vice versa.
                    rr_ptr_d = arb_winner[0];
                end
            end
            StSession: begin
                if (lock_error || timed_out) begin
                    fail_d     = 1'b1;
                    fail_cnt_d = fail_cnt_inc;
                    gnt_d      = '0;
                    state_d    = (fail_cnt_inc == MaxFails) ? StLockout : StIdle;
                end else if (lock_unlock) begin
                    pass_d     = 1'b1;
                    fail_cnt_d = '0;
                    state_d    = StOpen;
                end else if (!owner_req) begin
                    gnt_d      = '0;
                    state_d    = StIdle;
                end
            end
            StOpen: begin
                if (!owner_req) begin
                    gnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StLockout: begin
                if (lo_cnt_q == LoLast) begin
                    fail_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    lo_cnt_d = lo_cnt_q + LoW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            rr_ptr_q   <= 1'b0;
            fail_cnt_q <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            lo_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            fail_cnt_q <= fail_cnt_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            lo_cnt_q   <= lo_cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign fail_cnt   = fail_cnt_q;
    assign unlocked   = (state_q == StOpen);
    assign lockout    = (state_q == StLockout);
    assign lock_reset = reset | (state_q == StIdle) | (state_q == StLockout);
    assign lock_comb1 = in_session & |(u_comb1 & gnt_q);
    assign lock_comb2 = in_session & |(u_comb2 & gnt_q);
    assign lock_enter = in_session & |(u_enter & gnt_q);

endmodule
